// File: rtl/mcc_pkg.sv
// Shared definitions for the multi-cycle MIPS control FSM: state encodings, opcodes, the
// datapath mux/ALU codes and the registered-state control word produced by mcc_output_decode.
package mcc_pkg;

  localparam int unsigned StateBits = 4;

  typedef enum logic [StateBits-1:0] {
    StIdle     = 4'd0,
    StFetch    = 4'd1,
    StDecode   = 4'd2,
    StMemAdr   = 4'd3,
    StMemRd    = 4'd4,
    StMemWb    = 4'd5,
    StMemWr    = 4'd6,
    StExec     = 4'd7,
    StAluWb    = 4'd8,
    StBranch   = 4'd9,
    StAddiEx   = 4'd10,
    StAddiWb   = 4'd11,
    StJump     = 4'd12,
    StBranchNe = 4'd13
  } state_e;

  // Opcodes
  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  // aluop codes seen by alu_decoder
  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpSub   = 2'b01;
  localparam logic [1:0] AluOpFunct = 2'b10;

  // ALU B-input select
  localparam logic [1:0] SrcBRt    = 2'b00;
  localparam logic [1:0] SrcBFour  = 2'b01;
  localparam logic [1:0] SrcBImm   = 2'b10;
  localparam logic [1:0] SrcBImmSh = 2'b11;

  // PC source select
  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

  // Pure Moore part of the control word; irwrite and the FETCH pcwrite are added by the top
  // because they depend on mem_ready.
  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       branch_ne;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
  } ctrl_t;

  // States that stall on the memory handshake
  function automatic logic is_wait_state(state_e s);
    return (s == StFetch) || (s == StMemRd) || (s == StMemWr);
  endfunction

endpackage

// File: rtl/mcc_output_decode.sv
// Combinational state -> control-word table for the multi-cycle controller.
// Ports:
//   state  in   current FSM state
//   ctrl   out  Moore control word (all fields 0 in states that do not drive them)
// Configuration: MCC_BNE_EN adds the BRANCH_NE row.
module mcc_output_decode
  import mcc_pkg::*;
(
  input  state_e state,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      StFetch: begin
        ctrl.memread = 1'b1;
        ctrl.alusrcb = SrcBFour;
        ctrl.aluop   = AluOpAdd;
        ctrl.pcsrc   = PcSrcAlu;
      end
      StDecode: begin
        // Branch target precomputed while the opcode is decoded
        ctrl.alusrcb = SrcBImmSh;
        ctrl.aluop   = AluOpAdd;
      end
      StMemAdr: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SrcBImm;
        ctrl.aluop   = AluOpAdd;
      end
      StMemRd: begin
        ctrl.iord    = 1'b1;
        ctrl.memread = 1'b1;
      end
      StMemWb: begin
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      StMemWr: begin
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
      end
      StExec: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SrcBRt;
        ctrl.aluop   = AluOpFunct;
      end
      StAluWb: begin
        ctrl.regdst   = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      StBranch: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SrcBRt;
        ctrl.aluop   = AluOpSub;
        ctrl.pcsrc   = PcSrcAluOut;
        ctrl.branch  = 1'b1;
      end
`ifdef MCC_BNE_EN
      StBranchNe: begin
        ctrl.alusrca   = 1'b1;
        ctrl.alusrcb   = SrcBRt;
        ctrl.aluop     = AluOpSub;
        ctrl.pcsrc     = PcSrcAluOut;
        ctrl.branch_ne = 1'b1;
      end
`endif
      StAddiEx: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SrcBImm;
        ctrl.aluop   = AluOpAdd;
      end
      StAddiWb: begin
        ctrl.regwrite = 1'b1;
      end
      StJump: begin
        ctrl.pcsrc   = PcSrcJump;
        ctrl.pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM for the multi-cycle MIPS datapath. Sequences each instruction over 3-5 states,
// stalls FETCH/MEMRD/MEMWR on mem_ready and raises a sticky mem_timeout after MEM_TIMEOUT
// consecutive stall cycles (the FSM keeps waiting).
// Ports: clk, rst_n (async, active low), op (IR opcode), mem_ready (memory handshake);
//   datapath controls pcwrite, branch, branch_ne, iord, memread, memwrite, irwrite, regdst,
//   memtoreg, regwrite, alusrca, alusrcb, pcsrc, aluop; status illegal_op, mem_timeout, state_o.
// Configuration: define MCC_BNE_EN to decode bne (000101); otherwise it is illegal and
//   branch_ne stays 0.
module multicycle_controller
  import mcc_pkg::*;
#(
  parameter int unsigned ALUOP_W     = 2,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned STATE_W     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         op,
  input  logic               mem_ready,
  output logic               pcwrite,
  output logic               branch,
  output logic               branch_ne,
  output logic               iord,
  output logic               memread,
  output logic               memwrite,
  output logic               irwrite,
  output logic               regdst,
  output logic               memtoreg,
  output logic               regwrite,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic [ALUOP_W-1:0] aluop,
  output logic               illegal_op,
  output logic               mem_timeout,
  output logic [STATE_W-1:0] state_o
);

  localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MEM_TIMEOUT);

  state_e          state_q, state_d;
  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
  logic            timeout_q, timeout_d;
  logic            op_legal;
  logic            fetch_done;
  ctrl_t           ctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    op_legal = 1'b1;
    case (state_q)
      StIdle:   state_d = StFetch;
      StFetch:  if (mem_ready) state_d = StDecode;
      StDecode: begin
        case (op)
          OpLw, OpSw: state_d = StMemAdr;
          OpRtype:    state_d = StExec;
          OpBeq:      state_d = StBranch;
          OpAddi:     state_d = StAddiEx;
          OpJ:        state_d = StJump;
`ifdef MCC_BNE_EN
          OpBne:      state_d = StBranchNe;
`endif
          default: begin
            state_d  = StFetch;
            op_legal = 1'b0;
          end
        endcase
      end
      // IR still holds the opcode, so it selects the load or store path
      StMemAdr:   state_d = (op == OpLw) ? StMemRd : StMemWr;
      StMemRd:    if (mem_ready) state_d = StMemWb;
      StMemWb:    state_d = StFetch;
      StMemWr:    if (mem_ready) state_d = StFetch;
      StExec:     state_d = StAluWb;
      StAluWb:    state_d = StFetch;
      StBranch:   state_d = StFetch;
      StBranchNe: state_d = StFetch;
      StAddiEx:   state_d = StAddiWb;
      StAddiWb:   state_d = StFetch;
      StJump:     state_d = StFetch;
      default:    state_d = StIdle;
    endcase
  end

  // Stall counter: runs only while a wait state sees mem_ready low; every wait state exits on
  // mem_ready, so clearing on mem_ready also covers clearing on state exit.
  always_comb begin
    wait_cnt_d = '0;
    timeout_d  = timeout_q;
    if (is_wait_state(state_q) && !mem_ready) begin
      wait_cnt_d = (wait_cnt_q == CntMax) ? wait_cnt_q : wait_cnt_q + CntW'(1);
      if (wait_cnt_d == CntMax) timeout_d = 1'b1;
    end
  end

  mcc_output_decode u_output_decode (
    .state (state_q),
    .ctrl  (ctrl)
  );

  assign fetch_done = (state_q == StFetch) && mem_ready;

  assign pcwrite     = ctrl.pcwrite | fetch_done;
  assign irwrite     = fetch_done;
  assign branch      = ctrl.branch;
  // Without MCC_BNE_EN the table has no BRANCH_NE row, so this is constant 0
  assign branch_ne   = ctrl.branch_ne;
  assign iord        = ctrl.iord;
  assign memread     = ctrl.memread;
  assign memwrite    = ctrl.memwrite;
  assign regdst      = ctrl.regdst;
  assign memtoreg    = ctrl.memtoreg;
  assign regwrite    = ctrl.regwrite;
  assign alusrca     = ctrl.alusrca;
  assign alusrcb     = ctrl.alusrcb;
  assign pcsrc       = ctrl.pcsrc;
  assign aluop       = ALUOP_W'(ctrl.aluop);
  assign illegal_op  = (state_q == StDecode) && !op_legal;
  assign mem_timeout = timeout_q;
  assign state_o     = STATE_W'(state_q);

endmodule
